// File: rtl/lsu_pkg.sv
// lsu_pkg
// Shared types and helpers for the TRV-32I load/store unit.
//   lsu_state_t  : controller states (IDLE, WRITE, READ, RESP)
//   F3_*         : RV32I funct3 encodings for memory accesses
//   lsu_is_legal : 1 when funct3 names a valid load or store
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Stores have no unsigned forms, so only B/H/W are legal for them.
  function automatic logic lsu_is_legal(input logic is_store, input logic [2:0] funct3);
    logic legal;
    case (funct3)
      F3_B, F3_H, F3_W: legal = 1'b1;
      F3_BU, F3_HU:     legal = !is_store;
      default:          legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align
// Combinational lane logic for the load/store unit.
//   funct3     in  : access size/sign (funct3[1:0] = size, funct3[2] = unsigned)
//   addr_lo    in  : byte offset inside the word
//   wdata      in  : right-justified store data
//   rdata_raw  in  : raw word read from memory
//   byte_en    out : byte-lane enables for a store
//   store_data out : store data replicated into every lane of its size
//   load_data  out : addressed lanes shifted to bit 0 and extended
//   misaligned out : offset not a multiple of the access size
module lsu_align (
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_raw,
  output logic [3:0]  byte_en,
  output logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [31:0] byte_shift;
  logic [31:0] half_shift;

  // Replicating the store data means the selected lanes always hold the
  // right bytes whatever the offset; the byte enables pick which ones land.
  always_comb begin
    byte_shift = rdata_raw >> {addr_lo, 3'b000};
    half_shift = rdata_raw >> {addr_lo[1], 4'b0000};
    byte_en    = 4'b1111;
    store_data = wdata;
    load_data  = rdata_raw;
    misaligned = 1'b0;
    case (funct3[1:0])
      2'b00: begin
        byte_en    = 4'b0001 << addr_lo;
        store_data = {4{wdata[7:0]}};
        load_data  = funct3[2] ? {24'b0, byte_shift[7:0]}
                               : {{24{byte_shift[7]}}, byte_shift[7:0]};
      end
      2'b01: begin
        byte_en    = 4'b0011 << {addr_lo[1], 1'b0};
        store_data = {2{wdata[15:0]}};
        load_data  = funct3[2] ? {16'b0, half_shift[15:0]}
                               : {{16{half_shift[15]}}, half_shift[15:0]};
        misaligned = addr_lo[0];
      end
      default: begin
        misaligned = |addr_lo;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit
// Data-side load/store unit: one request at a time, registered strobes,
// tri-state write bus.
//   clk, rst (async, active-low)
//   req_*        : request from execute (valid/ready handshake)
//   resp_*       : one-cycle response with extended load data and fault flags
//   mem_addr     : word address, held for the whole access
//   mem_read_en / mem_write_en / write_byte_en : memory strobes
//   mem_data     : shared bus, driven only while writing
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int B_WIDTH  = 32,
  parameter int READ_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_is_store,
  input  logic [2:0]           req_funct3,
  input  logic [B_WIDTH-1:0]   req_addr,
  input  logic [B_WIDTH-1:0]   req_wdata,
  output logic                 resp_valid,
  output logic [B_WIDTH-1:0]   resp_rdata,
  output logic                 resp_misaligned,
  output logic                 resp_illegal,
  output logic [B_WIDTH-1:0]   mem_addr,
  output logic                 mem_read_en,
  output logic                 mem_write_en,
  output logic [B_WIDTH/8-1:0] write_byte_en,
  inout  wire  [B_WIDTH-1:0]   mem_data
);

  localparam logic [2:0] READ_CNT_INIT = 3'(READ_LAT);

  lsu_state_t         state_q, state_d;
  logic [2:0]         funct3_q, funct3_d;
  logic [B_WIDTH-1:0] addr_q, addr_d;
  logic [B_WIDTH-1:0] wdata_q, wdata_d;
  logic [B_WIDTH-1:0] rdata_q, rdata_d;
  logic               misaligned_q, misaligned_d;
  logic               illegal_q, illegal_d;
  logic [2:0]         cnt_q, cnt_d;

  logic [2:0]         sel_funct3;
  logic [1:0]         sel_addr_lo;
  logic [3:0]         align_be;
  logic [31:0]        align_store;
  logic [31:0]        align_load;
  logic               align_mis;
  logic               req_legal;

  // In IDLE the aligner looks at the incoming request so the fault decision
  // is made on the accepting edge; afterwards it works on the captured copy.
  assign sel_funct3  = (state_q == IDLE) ? req_funct3 : funct3_q;
  assign sel_addr_lo = (state_q == IDLE) ? req_addr[1:0] : addr_q[1:0];
  assign req_legal   = lsu_is_legal(req_is_store, req_funct3);

  lsu_align u_align (
    .funct3     (sel_funct3),
    .addr_lo    (sel_addr_lo),
    .wdata      (wdata_q),
    .rdata_raw  (mem_data),
    .byte_en    (align_be),
    .store_data (align_store),
    .load_data  (align_load),
    .misaligned (align_mis)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      funct3_q     <= 3'b000;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      misaligned_q <= 1'b0;
      illegal_q    <= 1'b0;
      cnt_q        <= 3'd0;
    end else begin
      state_q      <= state_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      misaligned_q <= misaligned_d;
      illegal_q    <= illegal_d;
      cnt_q        <= cnt_d;
    end
  end

  // Outputs decode only the state register, so strobes never follow req_*
  // combinationally and drop the moment reset forces the state to IDLE.
  always_comb begin
    state_d      = state_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    misaligned_d = misaligned_q;
    illegal_d    = illegal_q;
    cnt_d        = cnt_q;

    req_ready     = (state_q == IDLE);
    mem_write_en  = (state_q == WRITE);
    mem_read_en   = (state_q == READ);
    resp_valid    = (state_q == RESP);
    write_byte_en = mem_write_en ? align_be : '0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          funct3_d     = req_funct3;
          addr_d       = req_addr;
          wdata_d      = req_wdata;
          rdata_d      = '0;
          cnt_d        = READ_CNT_INIT;
          illegal_d    = !req_legal;
          misaligned_d = req_legal && align_mis;
          if (!req_legal || align_mis) begin
            state_d = RESP;
          end else if (req_is_store) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      WRITE: begin
        state_d = RESP;
      end
      READ: begin
        if (cnt_q == 3'd1) begin
          rdata_d = align_load;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign mem_addr        = {addr_q[B_WIDTH-1:2], 2'b00};
  assign resp_rdata      = resp_valid ? rdata_q : '0;
  assign resp_misaligned = resp_valid && misaligned_q;
  assign resp_illegal    = resp_valid && illegal_q;
  assign mem_data        = mem_write_en ? align_store : 'z;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
// Table of load/store requests fed through the handshake; each accepted
// request pushes its expected response onto a queue, and a negedge monitor
// checks bus activity and pops/compares responses. Hand sequences cover
// requests offered while busy and reset in the middle of a read.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misaligned;
  logic        resp_illegal;
  logic [31:0] mem_addr;
  logic        mem_read_en;
  logic        mem_write_en;
  logic [3:0]  write_byte_en;
  wire  [31:0] mem_data;
  logic [31:0] mem_word;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rd_seen = 0;
  int wr_seen = 0;

  typedef struct {
    string       name;
    logic        is_store;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem_word;
    logic [3:0]  be;
    logic [31:0] wr_data;
    logic [31:0] rdata;
    logic        mis;
    logic        ill;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wr_data;
    logic [31:0] rdata;
    logic        mis;
    logic        ill;
    int          lat;
    int          rd_cycles;
    int          wr_cycles;
    int          accept_cyc;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[$];

  assign mem_data = mem_read_en ? mem_word : 'z;

  load_store_unit #(.B_WIDTH(32), .READ_LAT(LAT)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_is_store    (req_is_store),
    .req_funct3      (req_funct3),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_misaligned (resp_misaligned),
    .resp_illegal    (resp_illegal),
    .mem_addr        (mem_addr),
    .mem_read_en     (mem_read_en),
    .mem_write_en    (mem_write_en),
    .write_byte_en   (write_byte_en),
    .mem_data        (mem_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic reportFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: event seen, none expected", name);
  endtask

  // Expected bus and response behaviour is derived here from the request
  // alone: faults answer after one cycle with no access, stores take a
  // single write cycle, loads hold the read strobe for LAT cycles.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    int   n;
    bit   fault;
    fault       = v.ill || v.mis;
    e.name      = v.name;
    e.addr      = {v.addr[31:2], 2'b00};
    e.be        = v.be;
    e.wr_data   = v.wr_data;
    e.rdata     = v.rdata;
    e.mis       = v.mis;
    e.ill       = v.ill;
    e.lat       = fault ? 1 : (v.is_store ? 2 : LAT + 1);
    e.rd_cycles = (fault || v.is_store) ? 0 : LAT;
    e.wr_cycles = (!fault && v.is_store) ? 1 : 0;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) reportFail({v.name, " ready timeout"});
    req_is_store = v.is_store;
    req_funct3   = v.f3;
    req_addr     = v.addr;
    req_wdata    = v.wdata;
    mem_word     = v.mem_word;
    req_valid    = 1'b1;
    @(posedge clk);
    #1;
    req_valid    = 1'b0;
    e.accept_cyc = cyc;
    sb.push_back(e);
  endtask

  // Monitor: checks every write/read cycle against the oldest outstanding
  // request and compares each response pulse with the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      if (mem_read_en && mem_write_en) reportFail("strobe overlap");
      if (mem_read_en) begin
        rd_seen++;
        if (sb.size() > 0) checkOutput({sb[0].name, " read addr"}, mem_addr, sb[0].addr);
        else reportFail("unexpected read");
      end
      if (mem_write_en) begin
        wr_seen++;
        if (sb.size() > 0) begin
          logic [31:0] mask;
          mask = {{8{sb[0].be[3]}}, {8{sb[0].be[2]}}, {8{sb[0].be[1]}}, {8{sb[0].be[0]}}};
          checkOutput({sb[0].name, " be"}, {28'b0, write_byte_en}, {28'b0, sb[0].be});
          checkOutput({sb[0].name, " wdata"}, mem_data & mask, sb[0].wr_data & mask);
          checkOutput({sb[0].name, " write addr"}, mem_addr, sb[0].addr);
        end else begin
          reportFail("unexpected write");
        end
      end
      if (resp_valid) begin
        if (sb.size() == 0) begin
          reportFail("unexpected resp_valid");
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput({e.name, " rdata"}, resp_rdata, e.rdata);
          checkOutput({e.name, " misaligned"}, {31'b0, resp_misaligned}, {31'b0, e.mis});
          checkOutput({e.name, " illegal"}, {31'b0, resp_illegal}, {31'b0, e.ill});
          checkOutput({e.name, " latency"}, 32'(cyc - e.accept_cyc + 1), 32'(e.lat));
          checkOutput({e.name, " read cycles"}, 32'(rd_seen), 32'(e.rd_cycles));
          checkOutput({e.name, " write cycles"}, 32'(wr_seen), 32'(e.wr_cycles));
          rd_seen = 0;
          wr_seen = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rst          = 1'b0;
    req_valid    = 1'b0;
    req_is_store = 1'b0;
    req_funct3   = 3'b000;
    req_addr     = '0;
    req_wdata    = '0;
    mem_word     = '0;

    //                name        st  f3     addr          wdata          mem word       be       wr data        rdata          mis   ill
    vecs.push_back('{"SW 0x10",   1, F3_W,  32'h10,       32'hDEADBEEF,  32'h0,         4'b1111, 32'hDEADBEEF,  32'h0,         1'b0, 1'b0});
    vecs.push_back('{"SB 0x13",   1, F3_B,  32'h13,       32'h000000A5,  32'h0,         4'b1000, 32'hA5000000,  32'h0,         1'b0, 1'b0});
    vecs.push_back('{"SH 0x02",   1, F3_H,  32'h02,       32'h1234BEEF,  32'h0,         4'b1100, 32'hBEEF0000,  32'h0,         1'b0, 1'b0});
    vecs.push_back('{"SB 0x01",   1, F3_B,  32'h01,       32'h00000077,  32'h0,         4'b0010, 32'h00007700,  32'h0,         1'b0, 1'b0});
    vecs.push_back('{"LB 0x12",   0, F3_B,  32'h12,       32'h0,         32'h00800000,  4'b0000, 32'h0,         32'hFFFFFF80,  1'b0, 1'b0});
    vecs.push_back('{"LBU 0x12",  0, F3_BU, 32'h12,       32'h0,         32'h00800000,  4'b0000, 32'h0,         32'h00000080,  1'b0, 1'b0});
    vecs.push_back('{"LH 0x02",   0, F3_H,  32'h02,       32'h0,         32'h80011234,  4'b0000, 32'h0,         32'hFFFF8001,  1'b0, 1'b0});
    vecs.push_back('{"LHU 0x02",  0, F3_HU, 32'h02,       32'h0,         32'h80011234,  4'b0000, 32'h0,         32'h00008001,  1'b0, 1'b0});
    vecs.push_back('{"LH 0x00",   0, F3_H,  32'h00,       32'h0,         32'h80011234,  4'b0000, 32'h0,         32'h00001234,  1'b0, 1'b0});
    vecs.push_back('{"LW 0x20",   0, F3_W,  32'h20,       32'h0,         32'hCAFEF00D,  4'b0000, 32'h0,         32'hCAFEF00D,  1'b0, 1'b0});
    vecs.push_back('{"LB 0x01",   0, F3_B,  32'h01,       32'h0,         32'h00007F00,  4'b0000, 32'h0,         32'h0000007F,  1'b0, 1'b0});
    vecs.push_back('{"LB 0x03",   0, F3_B,  32'h03,       32'h0,         32'hAB000000,  4'b0000, 32'h0,         32'hFFFFFFAB,  1'b0, 1'b0});
    vecs.push_back('{"LBU 0x03",  0, F3_BU, 32'h03,       32'h0,         32'hAB000000,  4'b0000, 32'h0,         32'h000000AB,  1'b0, 1'b0});
    vecs.push_back('{"LH 0x03",   0, F3_H,  32'h03,       32'h0,         32'hFFFFFFFF,  4'b0000, 32'h0,         32'h0,         1'b1, 1'b0});
    vecs.push_back('{"LW 0x22",   0, F3_W,  32'h22,       32'h0,         32'hFFFFFFFF,  4'b0000, 32'h0,         32'h0,         1'b1, 1'b0});
    vecs.push_back('{"SW 0x01",   1, F3_W,  32'h01,       32'h11223344,  32'h0,         4'b0000, 32'h0,         32'h0,         1'b1, 1'b0});
    vecs.push_back('{"S f3=100",  1, 3'b100, 32'h10,      32'h55555555,  32'h0,         4'b0000, 32'h0,         32'h0,         1'b0, 1'b1});
    vecs.push_back('{"L f3=011",  0, 3'b011, 32'h10,      32'h0,         32'hFFFFFFFF,  4'b0000, 32'h0,         32'h0,         1'b0, 1'b1});
    vecs.push_back('{"L f3=110 a1", 0, 3'b110, 32'h11,    32'h0,         32'hFFFFFFFF,  4'b0000, 32'h0,         32'h0,         1'b0, 1'b1});

    #3;
    checkOutput("reset req_ready", {31'b0, req_ready}, 32'd1);
    checkOutput("reset resp_valid", {31'b0, resp_valid}, 32'd0);
    checkOutput("reset read_en", {31'b0, mem_read_en}, 32'd0);
    checkOutput("reset write_en", {31'b0, mem_write_en}, 32'd0);
    checkOutput("reset byte_en", {28'b0, write_byte_en}, 32'd0);
    checkOutput("reset mem_addr", mem_addr, 32'd0);
    checkOutput("reset resp_rdata", resp_rdata, 32'd0);

    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // A request offered while a load is in flight must be ignored: no write
    // may appear and the load must still complete with its own data.
    applyStimulus('{"LW busy", 0, F3_W, 32'h20, 32'h0, 32'h12345678, 4'b0000, 32'h0, 32'h12345678, 1'b0, 1'b0});
    req_is_store = 1'b1;
    req_funct3   = F3_W;
    req_addr     = 32'h40;
    req_wdata    = 32'hFFFF0000;
    req_valid    = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    req_valid    = 1'b0;

    // Reset during the second read cycle: bus released at once, no response.
    applyStimulus('{"LW reset", 0, F3_W, 32'h20, 32'h0, 32'h0BADF00D, 4'b0000, 32'h0, 32'h0BADF00D, 1'b0, 1'b0});
    @(posedge clk);
    #2;
    checkOutput("mid-read read_en before reset", {31'b0, mem_read_en}, 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("async reset read_en", {31'b0, mem_read_en}, 32'd0);
    checkOutput("async reset write_en", {31'b0, mem_write_en}, 32'd0);
    checkOutput("async reset req_ready", {31'b0, req_ready}, 32'd1);
    checkOutput("async reset resp_valid", {31'b0, resp_valid}, 32'd0);
    checkOutput("async reset mem_addr", mem_addr, 32'd0);
    sb.delete();
    rd_seen = 0;
    wr_seen = 0;
    @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);

    applyStimulus('{"LBU after reset", 0, F3_BU, 32'h12, 32'h0, 32'h00800000, 4'b0000, 32'h0, 32'h00000080, 1'b0, 1'b0});

    n = 0;
    while (sb.size() > 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      reportFail("response timeout");
      sb.delete();
    end
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit of the TRV-32I core. It sits between the execute stage and the data side of the memory interface. It accepts one memory request at a time over a valid/ready handshake, checks alignment, and forms the word address, byte enables and lane-shifted store data. It drives the shared bidirectional data bus only while writing. For loads, it extracts and sign- or zero-extends the addressed lanes and returns one response per accepted request.

## Interface
- `B_WIDTH`, 32: address and data width; must be 32.
- `READ_LAT`, 1: cycles `mem_read_en` is held before read data is sampled; range 1..7.

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request offered by execute.
- `req_ready`  out  1  unit can accept a request.
- `req_is_store`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- `req_addr`  in  B_WIDTH  byte address.
- `req_wdata`  in  B_WIDTH  store data, right-justified.
- `resp_valid`  out  1  one-cycle response pulse.
- `resp_rdata`  out  B_WIDTH  extended load data; 0 for stores and faults.
- `resp_misaligned`  out  1  address misaligned for size; no access made.
- `resp_illegal`  out  1  funct3 invalid for op; no access made.
- `mem_addr`  out  B_WIDTH  word address `{req_addr[31:2],2'b00}`.
- `mem_read_en`  out  1  read strobe.
- `mem_write_en`  out  1  write strobe.
- `write_byte_en`  out  B_WIDTH/8  byte-lane enables.
- `mem_data`  inout  B_WIDTH  driven only while `mem_write_en`=1; otherwise high-Z.

## Operation
- FSM states:
  - `IDLE`: `req_ready`=1. On `req_valid`, the request is captured into registers and then:
    - illegal → `RESP`
    - misaligned → `RESP`
    - store → `WRITE`
    - load → `READ`
- `WRITE` (1 cycle):
  - `mem_write_en`=1.
  - `write_byte_en` is `0001<<a[1:0]` for SB, `0011<<{a[1],1'b0}` for SH, `1111` for SW.
  - `mem_data` carries `wdata` replicated into the selected lanes.
  - Next state is `RESP`.
- `READ`:
  - `mem_read_en`=1 for exactly `READ_LAT` cycles, counted by a 3-bit down-counter.
  - `mem_data` is sampled on the last such cycle.
  - Next state is `RESP`.
- `RESP` (1 cycle): `resp_valid`=1, with data and flags from registers. Next state is `IDLE`.
- Alignment rules:
  - Halfword requires `a[0]`=0; word requires `a[1:0]`=0.
  - Byte accesses are never misaligned.
- Legal funct3 values:
  - Loads: 000, 001, 010, 100, 101.
  - Stores: 000, 001, 010.
  - Illegal takes priority over misaligned.
- Load extension: the lane selected by `a[1:0]` (byte) or `a[1]` (half) is shifted to bit 0. LB/LH sign-extend; LBU/LHU zero-extend.
- `req_*` are ignored outside `IDLE`.

## Timing
- Reset values (async, while `rst`=0): state `IDLE`, `req_ready`=1, all strobes and enables 0, `resp_*`=0, `mem_addr`=0, `mem_data` high-Z.
- Latency from acceptance edge to `resp_valid`:
  - Store: 2 cycles.
  - Load: `READ_LAT`+1 cycles.
  - Fault: 1 cycle.
- Throughput: one request per (latency+1) cycles. `req_ready` rises in the cycle after `RESP`.
- `mem_addr` is held stable from the first `WRITE`/`READ` cycle until the return to `IDLE`. Strobes are registered outputs, never combinational from `req_*`.
- Reset asserted mid-`WRITE` or mid-`READ` stops the access immediately and releases the bus. No response is issued for that request.
- `WRITE` and `READ` strobes are never high in the same cycle. `resp_valid` never lasts more than one cycle.

## Structure
- Package `lsu_pkg`:
  - State enum `lsu_state_t`: IDLE, WRITE, READ, RESP.
  - funct3 constants `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`.
  - Function `lsu_is_legal(is_store, funct3)`.
- Sub-module `lsu_align` (combinational):
  - Inputs: funct3, `addr[1:0]`, wdata, raw rdata.
  - Outputs: byte enables, lane-replicated store data, extended load data, misaligned flag.
- The FSM, counter and tri-state driver stay in `load_store_unit`.

## Test plan
- SW to 0x0000_0010, data 0xDEADBEEF → in the `WRITE` cycle, `write_byte_en`=1111, `mem_addr`=0x10 and `mem_data`=0xDEADBEEF; `resp_valid` pulses 2 cycles after acceptance.
- SB to 0x13, data 0x0000_00A5 → `write_byte_en`=1000 and `mem_data[31:24]`=0xA5; `mem_data` is high-Z in the cycles before and after.
- LB from 0x12 with memory word 0x0080_0000 → `resp_rdata`=0xFFFF_FF80. LBU from the same address → 0x0000_0080.
- LH from 0x0000_0003 → `resp_misaligned`=1, `resp_valid` 1 cycle after acceptance, and `mem_read_en` never asserted.
- Store with funct3=100 → `resp_illegal`=1 and no strobes. With `READ_LAT`=3, LW from 0x20 → `mem_read_en` high exactly 3 cycles.
- `rst` pulled low during the second `READ` cycle → all outputs return to reset values asynchronously, and there is no `resp_valid` after release.
